arms_fetch_stage: RTL

Instruction-fetch stage of the ARMS 64-bit five-stage pipelined LEGv8 core. Owns the program counter and drives iaddrbus to instruction memory. Captures the returned 32-bit instruction from ibus into the IF/ID pipeline register for the decode stage. Supports stall (hold), branch redirect with flush, and synchronous reset to a fixed start address.

---
 rtl/arms_fetch_stage_if.sv | 9 +
 rtl/arms_fetch_stage.sv | 60 ++++++
 2 files changed

// File: rtl/arms_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The fetch stage drives the address. Memory answers on the same cycle.
interface arms_fetch_stage_if;
    logic [63:0] iaddrbus;
    logic [31:0] ibus;

    modport master (output iaddrbus, input ibus);
    modport slave  (input iaddrbus, output ibus);
endinterface

// File: rtl/arms_fetch_stage.sv
// ARMS LEGv8 instruction-fetch stage: owns the PC and fills the IF/ID register.
// Priority on each edge is reset > branch redirect/flush > stall > sequential fetch.
module arms_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [63:0] PC_STEP   = 64'd4
) (
    input  logic                      clk,
    input  logic                      reset,
    arms_fetch_stage_if.master        imem,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [63:0]               branch_target,
    output logic [31:0]               ifid_instr,
    output logic [63:0]               ifid_pc,
    output logic                      ifid_valid,
    output logic [31:0]               fetch_count
);

    logic [63:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [63:0] r_ifid_pc;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;
    logic [63:0] w_branch_pc;

    // Redirect targets are word aligned; stray low bits are dropped silently.
    assign w_branch_pc = branch_target & ~64'h3;

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge value of r_pc, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_pc     <= 64'h0;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= 32'h0;
        end else if (branch_taken) begin
            // The word on ibus this cycle is on the wrong path and is never captured.
            r_pc         <= w_branch_pc;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= r_pc;
            r_ifid_valid <= 1'b0;
        end else if (!stall) begin
            r_pc          <= r_pc + PC_STEP;
            r_ifid_instr  <= imem.ibus;
            r_ifid_pc     <= r_pc;
            r_ifid_valid  <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem.iaddrbus = r_pc;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_valid    = r_ifid_valid;
    assign fetch_count   = r_fetch_count;

endmodule
